// File: rtl/delay_fifo_ctrl_if.sv
// Handshake bundle between the sampler/trigger control, the run/stop
// sequencer and the delay FIFO's valid pins.
interface delay_fifo_ctrl_if #(
   parameter int CNTW = 5,
   parameter int ACCW = 16
);
   logic            run_req;
   logic            stop_req;
   logic            src_valid;
   logic            fifo_valid_in;
   logic            fifo_valid_out;
   logic [CNTW-1:0] inflight;
   logic [ACCW-1:0] accepted;
   logic            busy;
   logic            drained;
   logic            err;

   // Driven by the sampler/trigger side and the FIFO model/instance.
   modport master (
      output run_req, stop_req, src_valid, fifo_valid_out,
      input  fifo_valid_in, inflight, accepted, busy, drained, err
   );

   // Seen by the sequencer itself.
   modport slave (
      input  run_req, stop_req, src_valid, fifo_valid_out,
      output fifo_valid_in, inflight, accepted, busy, drained, err
   );
endinterface

// File: rtl/delay_fifo_ctrl.sv
// Run/stop sequencer for a fixed-latency delay FIFO. Gates sampler strobes
// into the FIFO, counts samples in flight, drains the pipe on stop and flags
// underflow or a drain that never completes. The FIFO itself is not reset,
// so a holdoff of DELAY cycles after reset keeps stale valids from counting.
module delay_fifo_ctrl #(
   parameter int DELAY = 3,
   parameter int CNTW  = 5,
   parameter int ACCW  = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   delay_fifo_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNTW-1:0] DELAY_C  = CNTW'(DELAY);
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [ACCW-1:0] ACC_ONE  = ACCW'(1);
   localparam logic [ACCW-1:0] ACC_MAX  = '1;

   state_t          state_q, state_d;
   logic [CNTW-1:0] inflight_q, inflight_d;
   logic [CNTW-1:0] timer_q, timer_d;
   logic [ACCW-1:0] accepted_q, accepted_d;
   logic            err_q, err_d;
   logic            busy_q, drained_q;
   logic            valid_in;
   logic            active;

   // Strobes pass straight through only while running and not being stopped.
   assign valid_in = bus.src_valid & (state_q == ST_RUN) & ~bus.stop_req;
   assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   // Next-state, counter and error logic.
   always_comb begin
      state_d    = state_q;
      inflight_d = inflight_q;
      timer_d    = timer_q;
      accepted_d = accepted_q;
      err_d      = err_q;

      // Outstanding-sample bookkeeping; validOut is meaningless outside RUN/DRAIN.
      if (active) begin
         if (valid_in && !bus.fifo_valid_out) begin
            inflight_d = inflight_q + CNT_ONE;
         end else if (!valid_in && bus.fifo_valid_out) begin
            if (inflight_q == '0) begin
               err_d = 1'b1;
            end else begin
               inflight_d = inflight_q - CNT_ONE;
            end
         end
      end

      if (valid_in && (accepted_q != ACC_MAX)) begin
         accepted_d = accepted_q + ACC_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.run_req && (timer_q == '0)) begin
               state_d    = ST_RUN;
               accepted_d = '0;
            end else if (timer_q != '0) begin
               timer_d = timer_q - CNT_ONE;
            end
         end
         ST_RUN: begin
            if (bus.stop_req) begin
               state_d = ST_DRAIN;
               timer_d = DELAY_C;
            end
         end
         ST_DRAIN: begin
            if (inflight_q == '0) begin
               state_d = ST_DONE;
            end else if (timer_q == '0) begin
               // Samples went missing inside the FIFO: give up and resync.
               err_d      = 1'b1;
               inflight_d = '0;
               state_d    = ST_DONE;
            end else begin
               timer_d = timer_q - CNT_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers; reset restarts the post-reset holdoff.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         inflight_q <= '0;
         timer_q    <= DELAY_C;
         accepted_q <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         drained_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         timer_q    <= timer_d;
         accepted_q <= accepted_d;
         err_q      <= err_d;
         busy_q     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         drained_q  <= (state_d == ST_DONE);
      end
   end

   assign bus.fifo_valid_in = valid_in;
   assign bus.inflight      = inflight_q;
   assign bus.accepted      = accepted_q;
   assign bus.busy          = busy_q;
   assign bus.drained       = drained_q;
   assign bus.err           = err_q;

endmodule

// File: tb/tb_delay_fifo_ctrl.sv
// Bench for delay_fifo_ctrl: directed run/stop/drain scenarios against an
// emulated DELAY-cycle FIFO, a cycle model checked every negedge, and
// hand-computed spot values.
module tb_delay_fifo_ctrl;

   localparam int DELAY   = 3;
   localparam int CNTW    = 5;
   localparam int ACCW    = 4;
   localparam int ACC_MAX = (1 << ACCW) - 1;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   delay_fifo_ctrl_if #(.CNTW(CNTW), .ACCW(ACCW)) bus ();

   delay_fifo_ctrl #(.DELAY(DELAY), .CNTW(CNTW), .ACCW(ACCW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int nchk  = 0;
   int nfail = 0;

   // FIFO emulation, preloaded with stale valids as an unreset FIFO would hold.
   bit pipe [DELAY] = '{1'b1, 1'b1, 1'b1};

   // Behavioural model of the sequencer, one value per cycle.
   int m_valid = 0;
   int m_st, m_inf, m_acc, m_err, m_tmr;
   int cyc_no = 0;

   task automatic chk(input string name, input int got, input int exp);
      nchk++;
      if (got != exp) begin
         nfail++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_no, got, exp);
      end
   endtask

   // Compare this cycle's outputs, then advance the model and the FIFO.
   always @(negedge clk) begin
      int e_vin, vout, n_inf, n_acc, n_err, n_st, n_tmr;
      vout  = int'(bus.fifo_valid_out === 1'b1);
      e_vin = int'(m_valid != 0 && m_st == M_RUN && bus.src_valid && !bus.stop_req);
      if (m_valid != 0) begin
         chk("fifo_valid_in", int'(bus.fifo_valid_in), e_vin);
         chk("inflight",      int'(bus.inflight),      m_inf);
         chk("accepted",      int'(bus.accepted),      m_acc);
         chk("busy",          int'(bus.busy),          int'(m_st == M_RUN || m_st == M_DRAIN));
         chk("drained",       int'(bus.drained),       int'(m_st == M_DONE));
         chk("err",           int'(bus.err),           m_err);
      end
      if (rst) begin
         m_valid = 1;
         m_st = M_IDLE; m_inf = 0; m_acc = 0; m_err = 0; m_tmr = DELAY;
      end else if (m_valid != 0) begin
         n_inf = m_inf; n_err = m_err; n_st = m_st; n_tmr = m_tmr;
         n_acc = (m_acc + e_vin > ACC_MAX) ? ACC_MAX : m_acc + e_vin;
         if (m_st == M_RUN || m_st == M_DRAIN) begin
            n_inf = m_inf + e_vin - vout;
            if (n_inf < 0) begin
               n_inf = 0;
               n_err = 1;
            end
         end
         if (m_st == M_IDLE) begin
            if (bus.run_req && m_tmr == 0) begin
               n_st = M_RUN; n_acc = 0;
            end else if (m_tmr > 0) begin
               n_tmr = m_tmr - 1;
            end
         end else if (m_st == M_RUN) begin
            if (bus.stop_req) begin
               n_st = M_DRAIN; n_tmr = DELAY;
            end
         end else if (m_st == M_DRAIN) begin
            if (m_inf == 0) n_st = M_DONE;
            else if (m_tmr == 0) begin
               n_st = M_DONE; n_err = 1; n_inf = 0;
            end else n_tmr = m_tmr - 1;
         end else begin
            n_st = M_IDLE;
         end
         m_st = n_st; m_inf = n_inf; m_acc = n_acc; m_err = n_err; m_tmr = n_tmr;
      end
      for (int i = DELAY - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = (bus.fifo_valid_in === 1'b1);
      cyc_no++;
   end

   // One clock of stimulus. vm: 0 = FIFO output, 1 = withhold, 2 = inject.
   task automatic cyc(input bit r, input bit run, input bit stop, input bit src, input int vm);
      @(posedge clk);
      #1;
      rst          = r;
      bus.run_req  = run;
      bus.stop_req = stop;
      bus.src_valid = src;
      if (vm == 1)      bus.fifo_valid_out = 1'b0;
      else if (vm == 2) bus.fifo_valid_out = 1'b1;
      else              bus.fifo_valid_out = pipe[DELAY-1];
      #1;
   endtask

   initial begin
      bus.run_req = 1'b0; bus.stop_req = 1'b0;
      bus.src_valid = 1'b0; bus.fifo_valid_out = 1'b0;

      cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
      // Holdoff: early run_req ignored, run_req at cycle 3 enters RUN at 4.
      cyc(0, 1, 0, 0, 0); chk("t1_busy_c0", int'(bus.busy), 0);
      cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0); chk("t1_busy_c3", int'(bus.busy), 0);
      cyc(0, 0, 0, 1, 0); chk("t1_busy_c4", int'(bus.busy), 1);
      // Steady stream: inflight ramps to DELAY.
      cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); chk("t2_inflight_c7", int'(bus.inflight), 3);
      chk("t2_accepted_c7", int'(bus.accepted), 3);
      cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
      // Stop at cycle 10 and drain.
      cyc(0, 0, 1, 1, 0); chk("t3_vin_c10", int'(bus.fifo_valid_in), 0);
      cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); chk("t3_inflight_c13", int'(bus.inflight), 0);
      chk("t3_drained_c13", int'(bus.drained), 0);
      cyc(0, 0, 0, 1, 0); chk("t3_drained_c14", int'(bus.drained), 1);
      cyc(0, 0, 0, 0, 0); chk("t3_drained_c15", int'(bus.drained), 0);
      chk("t3_err_c15", int'(bus.err), 0);
      chk("t3_accepted_c15", int'(bus.accepted), 6);
      // Drain timeout with validOut withheld.
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 1);
      for (int i = 20; i <= 23; i++) cyc(0, 0, 0, 0, 1);
      chk("t4_err_c23", int'(bus.err), 0);
      cyc(0, 0, 0, 0, 1); chk("t4_err_c24", int'(bus.err), 1);
      chk("t4_inflight_c24", int'(bus.inflight), 0);
      chk("t4_drained_c24", int'(bus.drained), 1);
      cyc(0, 0, 0, 0, 0); chk("t4_busy_c25", int'(bus.busy), 0);
      // Underflow in RUN, then run_req+stop_req together.
      cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 2); chk("t5_err_d4", int'(bus.err), 0);
      cyc(0, 1, 1, 0, 0); chk("t5_err_d5", int'(bus.err), 1);
      chk("t5_inflight_d5", int'(bus.inflight), 0);
      cyc(0, 0, 0, 0, 0); chk("t5_busy_d6", int'(bus.busy), 1);
      cyc(0, 0, 0, 0, 0); chk("t5_drained_d7", int'(bus.drained), 1);
      cyc(0, 0, 0, 0, 0); chk("t5_busy_d8", int'(bus.busy), 0);
      // Saturation of accepted, then reset in the middle of DRAIN.
      cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 1, 0); chk("t6_accepted_d24", int'(bus.accepted), 15);
      chk("t6_inflight_d24", int'(bus.inflight), 3);
      cyc(1, 0, 0, 0, 0); chk("t6_busy_d25", int'(bus.busy), 1);
      cyc(0, 1, 0, 0, 0);
      chk("t6_busy_d26", int'(bus.busy), 0);
      chk("t6_inflight_d26", int'(bus.inflight), 0);
      chk("t6_accepted_d26", int'(bus.accepted), 0);
      chk("t6_err_d26", int'(bus.err), 0);
      chk("t6_drained_d26", int'(bus.drained), 0);
      cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0); chk("t6_busy_d29", int'(bus.busy), 0);
      cyc(0, 0, 0, 0, 0); chk("t6_busy_d30", int'(bus.busy), 1);
      chk("t6_err_d30", int'(bus.err), 0);
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
